// File: rtl/maquina_maluca_pkg.sv
// Shared definitions for the coffee-making sequencer.
// Holds the 4-bit state type and the fixed state codes. Codes are also
// exported on the top-level status port, so the encoding must not change.
package maquina_maluca_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    INICIO              = 4'd0,
    IDLE                = 4'd1,
    LIGAR_MAQUINA       = 4'd2,
    VERIFICAR_AGUA      = 4'd3,
    ENCHER_RESERVATORIO = 4'd4,
    MOER_CAFE           = 4'd5,
    COLOCAR_NO_FILTRO   = 4'd6,
    PASSAR_AGITADOR     = 4'd7,
    TAMPEAR             = 4'd8,
    REALIZAR_EXTRACAO   = 4'd9
  } state_t;

endpackage

// File: rtl/maquina_maluca.sv
// Coffee-making sequencer FSM.
// Waits in IDLE for start, then walks the brew sequence one state per
// clock and returns to IDLE. VERIFICAR_AGUA is visited twice per brew:
// first pass fills the reservoir, second pass moves on to grinding.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous reset, active HIGH despite the name
//   start - brew request, only looked at while in IDLE
//   state - current state code (registered, straight from the state flop)
module maquina_maluca
  import maquina_maluca_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [STATE_W-1:0] state
);

  state_t state_q, state_d;
  logic   agua_ok_q, agua_ok_d;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= INICIO;
      agua_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      agua_ok_q <= agua_ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    agua_ok_d = agua_ok_q;
    case (state_q)
      INICIO:              state_d = IDLE;
      IDLE:                state_d = start ? LIGAR_MAQUINA : IDLE;
      LIGAR_MAQUINA: begin
        // Every brew starts with the reservoir considered empty, so the
        // first water check always goes through the fill step.
        state_d   = VERIFICAR_AGUA;
        agua_ok_d = 1'b0;
      end
      VERIFICAR_AGUA:      state_d = agua_ok_q ? MOER_CAFE : ENCHER_RESERVATORIO;
      ENCHER_RESERVATORIO: begin
        state_d   = VERIFICAR_AGUA;
        agua_ok_d = 1'b1;
      end
      MOER_CAFE:           state_d = COLOCAR_NO_FILTRO;
      COLOCAR_NO_FILTRO:   state_d = PASSAR_AGITADOR;
      PASSAR_AGITADOR:     state_d = TAMPEAR;
      TAMPEAR:             state_d = REALIZAR_EXTRACAO;
      REALIZAR_EXTRACAO:   state_d = IDLE;
      // Codes 10..15 recover to IDLE; the water flag is left alone.
      default:             state_d = IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_maquina_maluca.sv
module tb_maquina_maluca;
  import maquina_maluca_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  maquina_maluca dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .state (state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, advance past the edge, settle.
  task automatic drive(input logic r, input logic s);
    rst_n = r;
    start = s;
    @(posedge clk);
    #1;
  endtask

  task automatic push_brew();
    exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4);
    exp_q.push_back(4'd3); exp_q.push_back(4'd5); exp_q.push_back(4'd6);
    exp_q.push_back(4'd7); exp_q.push_back(4'd8); exp_q.push_back(4'd9);
    exp_q.push_back(4'd1);
  endtask

  task automatic test_reset();
    logic [3:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(4'd0);
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %0d exp %0d", i, state, e);
      end
    end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(4'd1);
      drive(1'b0, 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL reset_release[%0d] got %0d exp %0d", i, state, e);
      end
    end
  endtask

  task automatic test_start_pulse();
    logic [3:0] e;
    push_brew();
    exp_q.push_back(4'd1); exp_q.push_back(4'd1);
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, (i < 2) ? 1'b1 : 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL start_pulse[%0d] got %0d exp %0d", i, state, e);
      end
    end
  endtask

  task automatic test_start_held();
    logic [3:0] e;
    push_brew();
    push_brew();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL start_held[%0d] got %0d exp %0d", i, state, e);
      end
    end
    exp_q.push_back(4'd1);
    drive(1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (state !== e) begin
      errors++;
      $display("FAIL start_held_drop got %0d exp %0d", state, e);
    end
  endtask

  task automatic test_start_ignored();
    logic [3:0] e;
    push_brew();
    exp_q.push_back(4'd1);
    for (int i = 0; i < 11; i++) begin
      // First edge starts the brew; the last edge is in IDLE and must be 0.
      // Everything in between is random noise on start.
      if (i == 0)       drive(1'b0, 1'b1);
      else if (i == 10) drive(1'b0, 1'b0);
      else              drive(1'b0, 1'($urandom_range(0, 1)));
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL start_ignored[%0d] got %0d exp %0d", i, state, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] e;
    exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4);
    exp_q.push_back(4'd3); exp_q.push_back(4'd5); exp_q.push_back(4'd6);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (i == 0) ? 1'b1 : 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL reset_mid_pre[%0d] got %0d exp %0d", i, state, e);
      end
    end
    exp_q.push_back(4'd0);
    drive(1'b1, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (state !== e) begin
      errors++;
      $display("FAIL reset_mid_rst got %0d exp %0d", state, e);
    end
    exp_q.push_back(4'd1);
    drive(1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (state !== e) begin
      errors++;
      $display("FAIL reset_mid_release got %0d exp %0d", state, e);
    end
    push_brew();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, (i == 0) ? 1'b1 : 1'b0);
      e = exp_q.pop_front();
      checks++;
      if (state !== e) begin
        errors++;
        $display("FAIL reset_mid_rebrew[%0d] got %0d exp %0d", i, state, e);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] e;
    // Park in a brew state so recovery to IDLE is distinguishable from
    // simply following the old state.
    exp_q.push_back(4'd2);
    drive(1'b0, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (state !== e) begin
      errors++;
      $display("FAIL illegal_setup got %0d exp %0d", state, e);
    end
    @(negedge clk);
    force dut.state_q = state_t'(4'd12);
    #1;
    release dut.state_q;
    exp_q.push_back(4'd1);
    drive(1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (state !== e) begin
      errors++;
      $display("FAIL illegal_recover got %0d exp %0d", state, e);
    end
    exp_q.push_back(4'd1);
    drive(1'b0, 1'b0);
    e = exp_q.pop_front();
    checks++;
    if (state !== e) begin
      errors++;
      $display("FAIL illegal_hold got %0d exp %0d", state, e);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    #2;
    test_reset();
    test_start_pulse();
    test_start_held();
    test_start_ignored();
    test_reset_mid();
    test_illegal();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maquina_maluca.md
Name: maquina_maluca

Overview:
- Coffee-making sequencer FSM. After reset it waits in IDLE for a start request, then steps one state per clock through the brewing sequence and returns to IDLE.
- The water-check state is visited twice: the first visit fills the reservoir, the second proceeds to grinding.
- Current state code is exported directly for status display and verification.

Parameters:
- none (state encodings fixed; see Behaviour)

Ports:
- clk  input  1  single system clock; all state changes on rising edge
- rst_n  input  1  synchronous reset, active-high (asserted when 1), sampled on rising clk
- start  input  1  brew request; level-sampled only while in IDLE
- state  output  4  current FSM state code, registered

Behaviour:
- State encoding (4-bit, fixed):
  - 0 INICIO
  - 1 IDLE
  - 2 LIGAR_MAQUINA
  - 3 VERIFICAR_AGUA
  - 4 ENCHER_RESERVATORIO
  - 5 MOER_CAFE
  - 6 COLOCAR_NO_FILTRO
  - 7 PASSAR_AGITADOR
  - 8 TAMPEAR
  - 9 REALIZAR_EXTRACAO
- Reset: on a rising clk with rst_n=1, state <= INICIO (0) and internal flag agua_ok <= 0. Reset has priority over all transitions, including mid-sequence.
- Transitions (rst_n=0), each state lasts exactly 1 cycle unless noted:
  - INICIO -> IDLE unconditionally.
  - IDLE -> LIGAR_MAQUINA if start=1, else stay IDLE.
  - LIGAR_MAQUINA -> VERIFICAR_AGUA; agua_ok <= 0.
  - VERIFICAR_AGUA -> ENCHER_RESERVATORIO if agua_ok=0; -> MOER_CAFE if agua_ok=1.
  - ENCHER_RESERVATORIO -> VERIFICAR_AGUA; agua_ok <= 1.
  - MOER_CAFE -> COLOCAR_NO_FILTRO -> PASSAR_AGITADOR -> TAMPEAR -> REALIZAR_EXTRACAO -> IDLE.
- Full brew cycle: IDLE with start=1 at edge N gives state=2 after edge N. The sequence 2,3,4,3,5,6,7,8,9 runs on consecutive cycles, reaching IDLE (1) 10 edges after leaving IDLE.
- start is ignored in all states except IDLE. If start is still 1 when IDLE is re-entered, a new cycle begins on the next edge.
- Illegal codes 10..15 -> IDLE on next edge; agua_ok unchanged.
- state output is the state register itself; no combinational path from start to state.

Decomposition:
- Package maquina_maluca_pkg: 4-bit state type and the ten named state constants (0..9).
- Single module containing:
  - state register
  - agua_ok flag register
  - next-state combinational block
- No sub-module warranted.

Test Plan:
- Reset: hold rst_n=1 for 2 edges -> state=0. Release -> state=1 one edge later, and stays 1 with start=0.
- Start pulse: start=1 for 1–2 cycles in IDLE -> state sequence exactly 2,3,4,3,5,6,7,8,9,1 on consecutive edges, then holds at 1.
- Start held high: start=1 continuously -> after returning to 1, the next edge goes to 2 and the sequence repeats, again including the 4 (fill) visit.
- Start ignored mid-sequence: toggle start during states 3..9 -> sequence unchanged.
- Reset mid-operation: assert rst_n=1 while state=6 -> state=0 at next edge. After release: 1; a new start gives full sequence with fill (4) again.
- Illegal state via force to 12 -> state=1 next edge.
